// File: rtl/axi_pipeline_add_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
package axi_add_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int arb_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_pipeline_add_arb_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after
// start, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    int unsigned j;
    logic [W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j    = (32'(start) + k) % N;
      cand = W'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axi_pipeline_add_arb.sv
// Round-robin scheduler sharing one axi_pipeline_add between NUM_REQ streams;
// beats are tagged {last, id, user} and results are steered back by the tag.
module axi_pipeline_add_arb
  import axi_add_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DWIDTH     = 32,
  parameter  int UWIDTH     = 8,
  localparam int ID_W       = arb_id_w(NUM_REQ),
  localparam int ADD_UWIDTH = 1 + ID_W + UWIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        s_valid,
  output logic [NUM_REQ-1:0]        s_ready,
  input  logic [NUM_REQ-1:0]        s_last,
  input  logic [NUM_REQ*DWIDTH-1:0] s_data_a,
  input  logic [NUM_REQ*DWIDTH-1:0] s_data_b,
  input  logic [NUM_REQ*UWIDTH-1:0] s_user,
  output logic                      add_s_valid,
  input  logic                      add_s_ready,
  output logic [DWIDTH-1:0]         add_s_data_a,
  output logic [DWIDTH-1:0]         add_s_data_b,
  output logic [ADD_UWIDTH-1:0]     add_s_user,
  input  logic                      add_m_valid,
  output logic                      add_m_ready,
  input  logic [DWIDTH-1:0]         add_m_data_a,
  input  logic [DWIDTH-1:0]         add_m_data_b,
  input  logic [DWIDTH-1:0]         add_m_data_result,
  input  logic                      add_m_data_carry,
  input  logic [ADD_UWIDTH-1:0]     add_m_user,
  output logic [NUM_REQ-1:0]        r_valid,
  input  logic [NUM_REQ-1:0]        r_ready,
  output logic [DWIDTH-1:0]         r_data_a,
  output logic [DWIDTH-1:0]         r_data_b,
  output logic [DWIDTH-1:0]         r_result,
  output logic                      r_carry,
  output logic                      r_last,
  output logic [UWIDTH-1:0]         r_user,
  output logic                      id_err
);

  localparam logic [ID_W:0] NUM_REQ_L = (ID_W + 1)'(NUM_REQ);

  arb_state_t      state, state_nxt;
  logic [ID_W-1:0] gnt, gnt_nxt;
  logic [ID_W-1:0] last_gnt, last_gnt_nxt;
  logic [ID_W-1:0] pick_start, pick_idx;
  logic            pick_found;

  logic [DWIDTH-1:0] a_arr [NUM_REQ];
  logic [DWIDTH-1:0] b_arr [NUM_REQ];
  logic [UWIDTH-1:0] u_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = s_data_a[g*DWIDTH +: DWIDTH];
    assign b_arr[g] = s_data_b[g*DWIDTH +: DWIDTH];
    assign u_arr[g] = s_user[g*UWIDTH +: UWIDTH];
  end

  assign pick_start = (last_gnt == ID_W'(NUM_REQ - 1)) ? '0 : last_gnt + 1'b1;

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_pick (
    .req   (s_valid),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Result path: tag decode and out-of-range detection.
  logic [ID_W-1:0] rid;
  logic            rid_ok;

  assign rid    = add_m_user[UWIDTH +: ID_W];
  assign rid_ok = ({1'b0, rid} < NUM_REQ_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      gnt      <= '0;
      last_gnt <= ID_W'(NUM_REQ - 1);
      id_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
      if (add_m_valid && !rid_ok) id_err <= 1'b1;
    end
  end

  // Handshakes are gated by rst so nothing is accepted while the adder flushes.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    add_s_valid  = 1'b0;
    s_ready      = '0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_nxt = ARB_LOCKED;
          gnt_nxt   = pick_idx;
        end
      end
      ARB_LOCKED: begin
        if (!rst) begin
          add_s_valid  = s_valid[gnt];
          s_ready[gnt] = add_s_ready;
        end
        if (s_valid[gnt] && add_s_ready && s_last[gnt]) begin
          last_gnt_nxt = gnt;
          state_nxt    = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign add_s_data_a = a_arr[gnt];
  assign add_s_data_b = b_arr[gnt];
  assign add_s_user   = {s_last[gnt], gnt, u_arr[gnt]};

  always_comb begin
    r_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      r_valid[i] = add_m_valid && rid_ok && (rid == ID_W'(i));
    end
  end

  assign add_m_ready = rid_ok ? r_ready[rid] : 1'b1;
  assign r_data_a    = add_m_data_a;
  assign r_data_b    = add_m_data_b;
  assign r_result    = add_m_data_result;
  assign r_carry     = add_m_data_carry;
  assign r_last      = add_m_user[UWIDTH + ID_W];
  assign r_user      = add_m_user[UWIDTH-1:0];

endmodule

// File: tb/tb_axi_pipeline_add_arb.sv
// Self-checking bench for axi_pipeline_add_arb with a queue-based adder model.
module tb_axi_pipeline_add_arb;
  localparam int NR = 4, DW = 32, UW = 8, IW = 2, AUW = 1 + IW + UW;
  localparam int NR3 = 3, AUW3 = 1 + 2 + UW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [NR-1:0]    s_valid, s_ready, s_last;
  logic [NR*DW-1:0] s_data_a, s_data_b;
  logic [NR*UW-1:0] s_user;
  logic             add_s_valid;
  logic             add_s_ready = 1'b0;
  logic [DW-1:0]    add_s_data_a, add_s_data_b;
  logic [AUW-1:0]   add_s_user;
  logic             add_m_valid = 1'b0;
  logic             add_m_ready;
  logic [DW-1:0]    add_m_data_a = '0, add_m_data_b = '0, add_m_data_result = '0;
  logic             add_m_data_carry = 1'b0;
  logic [AUW-1:0]   add_m_user = '0;
  logic [NR-1:0]    r_valid, r_ready;
  logic [DW-1:0]    r_data_a, r_data_b, r_result;
  logic             r_carry, r_last, id_err;
  logic [UW-1:0]    r_user;

  axi_pipeline_add_arb #(.NUM_REQ(NR), .DWIDTH(DW), .UWIDTH(UW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_data_a(s_data_a), .s_data_b(s_data_b), .s_user(s_user),
    .add_s_valid(add_s_valid), .add_s_ready(add_s_ready), .add_s_data_a(add_s_data_a),
    .add_s_data_b(add_s_data_b), .add_s_user(add_s_user),
    .add_m_valid(add_m_valid), .add_m_ready(add_m_ready), .add_m_data_a(add_m_data_a),
    .add_m_data_b(add_m_data_b), .add_m_data_result(add_m_data_result),
    .add_m_data_carry(add_m_data_carry), .add_m_user(add_m_user),
    .r_valid(r_valid), .r_ready(r_ready), .r_data_a(r_data_a), .r_data_b(r_data_b),
    .r_result(r_result), .r_carry(r_carry), .r_last(r_last), .r_user(r_user), .id_err(id_err));

  // Second instance with a non power-of-two requester count, adder side driven directly.
  logic [NR3-1:0]    t3_s_valid, t3_s_ready, t3_s_last, t3_r_valid, t3_r_ready;
  logic [NR3*DW-1:0] t3_s_data_a, t3_s_data_b;
  logic [NR3*UW-1:0] t3_s_user;
  logic              t3_add_s_valid, t3_add_s_ready, t3_add_m_valid, t3_add_m_ready;
  logic [DW-1:0]     t3_add_s_data_a, t3_add_s_data_b, t3_r_data_a, t3_r_data_b, t3_r_result;
  logic [AUW3-1:0]   t3_add_s_user, t3_add_m_user;
  logic              t3_r_carry, t3_r_last, t3_id_err;
  logic [UW-1:0]     t3_r_user;

  axi_pipeline_add_arb #(.NUM_REQ(NR3), .DWIDTH(DW), .UWIDTH(UW)) dut3 (
    .clk(clk), .rst(rst), .s_valid(t3_s_valid), .s_ready(t3_s_ready), .s_last(t3_s_last),
    .s_data_a(t3_s_data_a), .s_data_b(t3_s_data_b), .s_user(t3_s_user),
    .add_s_valid(t3_add_s_valid), .add_s_ready(t3_add_s_ready), .add_s_data_a(t3_add_s_data_a),
    .add_s_data_b(t3_add_s_data_b), .add_s_user(t3_add_s_user),
    .add_m_valid(t3_add_m_valid), .add_m_ready(t3_add_m_ready), .add_m_data_a(32'h1),
    .add_m_data_b(32'h2), .add_m_data_result(32'h3), .add_m_data_carry(1'b0),
    .add_m_user(t3_add_m_user),
    .r_valid(t3_r_valid), .r_ready(t3_r_ready), .r_data_a(t3_r_data_a), .r_data_b(t3_r_data_b),
    .r_result(t3_r_result), .r_carry(t3_r_carry), .r_last(t3_r_last), .r_user(t3_r_user),
    .id_err(t3_id_err));

  // Adder model: elastic queue of depth 4, one-cycle latency, optional input stalls.
  typedef struct packed {logic [DW-1:0] a; logic [DW-1:0] b; logic [AUW-1:0] u;} add_ent_t;
  add_ent_t aq[$];
  bit add_stall;

  always @(posedge clk) begin
    add_ent_t e;
    logic [DW:0] s33;
    if (rst) aq.delete();
    else begin
      if (add_m_valid && add_m_ready) void'(aq.pop_front());
      if (add_s_valid && add_s_ready) begin
        e.a = add_s_data_a; e.b = add_s_data_b; e.u = add_s_user;
        aq.push_back(e);
      end
    end
    add_s_ready <= (aq.size() < 4) && !(add_stall && ($urandom_range(3) == 0));
    add_m_valid <= (aq.size() > 0);
    if (aq.size() > 0) begin
      s33 = {1'b0, aq[0].a} + {1'b0, aq[0].b};
      add_m_data_a      <= aq[0].a;
      add_m_data_b      <= aq[0].b;
      add_m_data_result <= s33[DW-1:0];
      add_m_data_carry  <= s33[DW];
      add_m_user        <= aq[0].u;
    end
  end

  typedef struct {logic [DW-1:0] a; logic [DW-1:0] b; logic [UW-1:0] u; logic last;} beat_t;
  typedef struct {int cyc; int tag; logic last;} alog_t;
  typedef struct packed {logic [DW-1:0] a; logic [DW-1:0] b; logic [DW-1:0] res;
                         logic carry; logic last; logic [UW-1:0] u;} res_t;

  beat_t   req_q [NR][$];
  beat_t   sent  [NR][$];
  res_t    obs   [NR][$];
  alog_t   alog[$];
  int      rv_cnt [NR];
  int      multi_rv, cyc, n_cmp, n_err;
  logic [NR-1:0] rdy_cfg, smp_s_ready;
  logic    smp_add_s_valid;
  bit      rdy_rand;

  function automatic res_t expect_of(input beat_t bt);
    logic [DW:0] s33;
    s33 = {1'b0, bt.a} + {1'b0, bt.b};
    return {bt.a, bt.b, s33[DW-1:0], s33[DW], bt.last, bt.u};
  endfunction

  task automatic add_pkt(input int r, input int len);
    beat_t bt;
    for (int k = 0; k < len; k++) begin
      bt.a = $urandom; bt.b = $urandom; bt.u = UW'($urandom); bt.last = (k == len - 1);
      req_q[r].push_back(bt); sent[r].push_back(bt);
    end
  endtask

  task automatic clear_logs();
    alog.delete();
    for (int i = 0; i < NR; i++) begin
      req_q[i].delete(); sent[i].delete(); obs[i].delete(); rv_cnt[i] = 0;
    end
    multi_rv = 0;
  endtask

  // One clock: drive at the falling edge, sample 1 time unit before the rising edge.
  task automatic step();
    alog_t e;
    res_t  r;
    for (int i = 0; i < NR; i++) begin
      s_valid[i] = (req_q[i].size() > 0);
      if (req_q[i].size() > 0) begin
        s_data_a[i*DW +: DW] = req_q[i][0].a;
        s_data_b[i*DW +: DW] = req_q[i][0].b;
        s_user[i*UW +: UW]   = req_q[i][0].u;
        s_last[i]            = req_q[i][0].last;
      end else s_last[i] = 1'($urandom);
    end
    r_ready = rdy_rand ? NR'($urandom) : rdy_cfg;
    #4;
    smp_s_ready = s_ready;
    smp_add_s_valid = add_s_valid;
    for (int i = 0; i < NR; i++)
      if (s_valid[i] && s_ready[i]) void'(req_q[i].pop_front());
    if (add_s_valid && add_s_ready) begin
      e.cyc = cyc; e.tag = int'(add_s_user[UW +: IW]); e.last = add_s_user[AUW-1];
      alog.push_back(e);
    end
    if ($countones(r_valid) > 1) multi_rv++;
    for (int i = 0; i < NR; i++) begin
      if (r_valid[i]) begin
        rv_cnt[i]++;
        if (r_ready[i]) begin
          r = {r_data_a, r_data_b, r_result, r_carry, r_last, r_user};
          obs[i].push_back(r);
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  function automatic bit pending();
    int so, ss;
    bit p;
    so = 0; ss = 0; p = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (req_q[i].size() > 0) p = 1'b1;
      so += obs[i].size(); ss += sent[i].size();
    end
    return p || (so < ss);
  endfunction

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (pending() && n < maxc) begin step(); n++; end
    n_cmp++;
    if (pending()) begin
      n_err++; $display("FAIL drain_timeout: still pending after %0d cycles, want drained", maxc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = '1; s_last = '1; r_ready = '1;
    repeat (3) begin
      #4;
      n_cmp++;
      if (s_ready !== '0 || add_s_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_hs: s_ready=%b add_s_valid=%b want 0000/0", s_ready, add_s_valid);
      end
      @(posedge clk); cyc++; @(negedge clk);
    end
    s_valid = '0;
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (smp_s_ready !== '0 || smp_add_s_valid !== 1'b0 || id_err !== 1'b0 || r_valid !== '0) begin
      n_err++;
      $display("FAIL reset_idle: s_ready=%b add_s_valid=%b id_err=%b r_valid=%b want all 0",
               smp_s_ready, smp_add_s_valid, id_err, r_valid);
    end
  endtask

  task automatic test_single();
    beat_t bt;
    int c0;
    clear_logs(); do_reset(); clear_logs();
    for (int k = 0; k < 3; k++) begin
      bt.a = 32'd5; bt.b = 32'd7; bt.u = UW'(8'hA0 + k); bt.last = (k == 2);
      req_q[2].push_back(bt); sent[2].push_back(bt);
    end
    c0 = cyc;
    step();
    n_cmp++;
    if (alog.size() != 0) begin
      n_err++; $display("FAIL single_grant_early: %0d beats in idle cycle, want 0", alog.size());
    end
    repeat (8) step();
    n_cmp++;
    if (alog.size() != 3) begin
      n_err++; $display("FAIL single_beats: got %0d adder beats want 3", alog.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (alog[k].cyc != c0 + 1 + k || alog[k].tag != 2 || alog[k].last !== (k == 2)) begin
          n_err++;
          $display("FAIL single_beat%0d: cyc=%0d tag=%0d last=%b want cyc=%0d tag=2 last=%b",
                   k, alog[k].cyc, alog[k].tag, alog[k].last, c0 + 1 + k, (k == 2));
        end
      end
    end
    n_cmp++;
    if (obs[2].size() != 3 || rv_cnt[0] + rv_cnt[1] + rv_cnt[3] != 0) begin
      n_err++;
      $display("FAIL single_route: r2 results=%0d others_valid=%0d want 3/0",
               obs[2].size(), rv_cnt[0] + rv_cnt[1] + rv_cnt[3]);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[2][k].res !== 32'd12 || obs[2][k].carry !== 1'b0 || obs[2][k].last !== (k == 2)) begin
          n_err++;
          $display("FAIL single_res%0d: res=%0d carry=%b last=%b want 12/0/%b",
                   k, obs[2][k].res, obs[2][k].carry, obs[2][k].last, (k == 2));
        end
      end
    end
  endtask

  task automatic test_all_simul();
    int c0;
    clear_logs(); do_reset(); clear_logs();
    for (int i = 0; i < NR; i++) add_pkt(i, 2);
    c0 = cyc;
    drain(60);
    n_cmp++;
    if (alog.size() != 2 * NR) begin
      n_err++; $display("FAIL simul_beats: got %0d want %0d", alog.size(), 2 * NR);
    end else begin
      for (int j = 0; j < 2 * NR; j++) begin
        n_cmp++;
        if (alog[j].tag != j / 2 || alog[j].last !== ((j % 2) == 1) ||
            alog[j].cyc != c0 + 1 + 3 * (j / 2) + (j % 2)) begin
          n_err++;
          $display("FAIL simul_order%0d: tag=%0d last=%b cyc=%0d want tag=%0d last=%b cyc=%0d",
                   j, alog[j].tag, alog[j].last, alog[j].cyc, j / 2, (j % 2) == 1,
                   c0 + 1 + 3 * (j / 2) + (j % 2));
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (obs[i].size() != sent[i].size()) begin
        n_err++; $display("FAIL simul_cnt_r%0d: got %0d want %0d", i, obs[i].size(), sent[i].size());
      end else begin
        for (int k = 0; k < sent[i].size(); k++) begin
          n_cmp++;
          if (obs[i][k] !== expect_of(sent[i][k])) begin
            n_err++; $display("FAIL simul_res_r%0d_%0d: got %h want %h", i, k, obs[i][k], expect_of(sent[i][k]));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    clear_logs(); do_reset(); clear_logs();
    add_pkt(0, 2); add_pkt(0, 2);
    c0 = cyc;
    drain(40);
    n_cmp++;
    if (alog.size() != 4) begin
      n_err++; $display("FAIL b2b_beats: got %0d want 4", alog.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_cmp++;
        if (alog[j].tag != 0 || alog[j].cyc != c0 + 1 + 3 * (j / 2) + (j % 2)) begin
          n_err++; $display("FAIL b2b_beat%0d: tag=%0d cyc=%0d want tag=0 cyc=%0d",
                            j, alog[j].tag, alog[j].cyc, c0 + 1 + 3 * (j / 2) + (j % 2));
        end
      end
    end
  endtask

  task automatic test_carry();
    beat_t bt;
    clear_logs();
    bt.a = 32'hFFFF_FFFF; bt.b = 32'd1; bt.u = 8'h3C; bt.last = 1'b1;
    req_q[1].push_back(bt); sent[1].push_back(bt);
    repeat (6) step();
    n_cmp++;
    if (obs[1].size() != 1 || rv_cnt[0] + rv_cnt[2] + rv_cnt[3] != 0) begin
      n_err++; $display("FAIL carry_route: r1 results=%0d others_valid=%0d want 1/0",
                        obs[1].size(), rv_cnt[0] + rv_cnt[2] + rv_cnt[3]);
    end else begin
      n_cmp++;
      if (obs[1][0].res !== 32'd0 || obs[1][0].carry !== 1'b1 || obs[1][0].u !== 8'h3C) begin
        n_err++; $display("FAIL carry_val: res=%h carry=%b user=%h want 0/1/3c",
                          obs[1][0].res, obs[1][0].carry, obs[1][0].u);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    rdy_cfg = 4'b0111;
    add_pkt(3, 6);
    repeat (10) step();
    n_cmp++;
    if (obs[3].size() != 0 || rv_cnt[3] == 0 || rv_cnt[0] + rv_cnt[1] + rv_cnt[2] != 0) begin
      n_err++; $display("FAIL bp_stall: r3 taken=%0d r3_valid=%0d others_valid=%0d want 0/>0/0",
                        obs[3].size(), rv_cnt[3], rv_cnt[0] + rv_cnt[1] + rv_cnt[2]);
    end
    rdy_cfg = '1;
    drain(60);
    n_cmp++;
    if (obs[3].size() != 6) begin
      n_err++; $display("FAIL bp_cnt: got %0d want 6", obs[3].size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
        if (obs[3][k] !== expect_of(sent[3][k])) begin
          n_err++; $display("FAIL bp_res%0d: got %h want %h", k, obs[3][k], expect_of(sent[3][k]));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    clear_logs(); do_reset(); clear_logs();
    add_pkt(1, 5);
    n = 0;
    while (alog.size() < 2 && n < 10) begin step(); n++; end
    n_cmp++;
    if (alog.size() != 2) begin
      n_err++; $display("FAIL midrst_pre: got %0d beats want 2", alog.size());
    end
    rst = 1'b1;
    repeat (2) begin
      step();
      n_cmp++;
      if (smp_s_ready !== '0 || smp_add_s_valid !== 1'b0) begin
        n_err++; $display("FAIL midrst_hs: s_ready=%b add_s_valid=%b want 0000/0", smp_s_ready, smp_add_s_valid);
      end
    end
    clear_logs();
    rst = 1'b0;
    step();
    n_cmp++;
    if (smp_s_ready !== '0 || smp_add_s_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_idle: s_ready=%b add_s_valid=%b want 0000/0", smp_s_ready, smp_add_s_valid);
    end
    add_pkt(1, 1); add_pkt(0, 1);
    repeat (8) step();
    n_cmp++;
    if (alog.size() != 2 || alog[0].tag != 0 || alog[1].tag != 1) begin
      n_err++; $display("FAIL midrst_order: beats=%0d first_tag=%0d want 2 beats, tags 0 then 1",
                        alog.size(), (alog.size() > 0) ? alog[0].tag : -1);
    end
  endtask

  task automatic test_random();
    int interleave, nobubble;
    clear_logs();
    rdy_rand = 1'b1; add_stall = 1'b1;
    for (int i = 0; i < NR; i++)
      repeat ($urandom_range(3, 1)) add_pkt(i, $urandom_range(4, 1));
    drain(3000);
    rdy_rand = 1'b0; add_stall = 1'b0;
    interleave = 0; nobubble = 0;
    for (int j = 1; j < alog.size(); j++) begin
      if (!alog[j-1].last && alog[j].tag != alog[j-1].tag) interleave++;
      if (alog[j-1].last && alog[j].cyc < alog[j-1].cyc + 2) nobubble++;
    end
    n_cmp++;
    if (interleave != 0 || nobubble != 0 || multi_rv != 0) begin
      n_err++; $display("FAIL rand_protocol: interleave=%0d no_bubble=%0d multi_rvalid=%0d want 0/0/0",
                        interleave, nobubble, multi_rv);
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (obs[i].size() != sent[i].size()) begin
        n_err++; $display("FAIL rand_cnt_r%0d: got %0d want %0d", i, obs[i].size(), sent[i].size());
      end else begin
        for (int k = 0; k < sent[i].size(); k++) begin
          n_cmp++;
          if (obs[i][k] !== expect_of(sent[i][k])) begin
            n_err++; $display("FAIL rand_res_r%0d_%0d: got %h want %h", i, k, obs[i][k], expect_of(sent[i][k]));
          end
        end
      end
    end
  endtask

  task automatic test_bad_tag();
    t3_add_m_valid = 1'b1; t3_add_m_user = {1'b0, 2'd3, 8'h55}; t3_r_ready = '0;
    #4;
    n_cmp++;
    if (t3_add_m_ready !== 1'b1 || t3_r_valid !== '0 || t3_id_err !== 1'b0) begin
      n_err++; $display("FAIL badtag_comb: ready=%b r_valid=%b id_err=%b want 1/000/0",
                        t3_add_m_ready, t3_r_valid, t3_id_err);
    end
    @(posedge clk); @(negedge clk);
    t3_add_m_valid = 1'b0;
    repeat (3) begin
      #4;
      n_cmp++;
      if (t3_id_err !== 1'b1) begin
        n_err++; $display("FAIL badtag_sticky: id_err=%b want 1", t3_id_err);
      end
      @(posedge clk); @(negedge clk);
    end
    t3_add_m_valid = 1'b1; t3_add_m_user = {1'b1, 2'd2, 8'h11}; t3_r_ready = 3'b011;
    #4;
    n_cmp++;
    if (t3_r_valid !== 3'b100 || t3_add_m_ready !== 1'b0 || t3_r_last !== 1'b1) begin
      n_err++; $display("FAIL tag2_route: r_valid=%b ready=%b last=%b want 100/0/1",
                        t3_r_valid, t3_add_m_ready, t3_r_last);
    end
    @(negedge clk);
    t3_add_m_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #4;
    n_cmp++;
    if (t3_id_err !== 1'b0) begin
      n_err++; $display("FAIL badtag_clear: id_err=%b want 0", t3_id_err);
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; multi_rv = 0;
    rdy_cfg = '1; rdy_rand = 1'b0; add_stall = 1'b0;
    s_valid = '0; s_last = '0; s_data_a = '0; s_data_b = '0; s_user = '0; r_ready = '1;
    t3_s_valid = '0; t3_s_last = '0; t3_s_data_a = '0; t3_s_data_b = '0; t3_s_user = '0;
    t3_add_s_ready = 1'b0; t3_add_m_valid = 1'b0; t3_add_m_user = '0; t3_r_ready = '0;
    rst = 1'b1;
    for (int i = 0; i < NR; i++) rv_cnt[i] = 0;
    test_reset();
    test_single();
    test_all_simul();
    test_back_to_back();
    test_carry();
    test_backpressure();
    test_mid_reset();
    test_random();
    test_bad_tag();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/axi_pipeline_add_arb.md
# axi_pipeline_add_arb

Round-robin scheduler that shares one `axi_pipeline_add` instance between `NUM_REQ` requester streams. It grants the adder input to one requester per packet and tags each beat with the requester index in the adder user field. It demultiplexes adder results back to the originating requester by that tag. It sits between the requester-side AXI-stream producers and the shared adder, and the parent instantiates the adder next to it.

## Interface
- `NUM_REQ`, 4: requester count, 2..16.
- `DWIDTH`, 32: operand and result width.
- `UWIDTH`, 8: per-requester sideband width, passed through untouched.
- `ID_W`, derived as max(1, clog2(NUM_REQ)); not overridable.
- `ADD_UWIDTH`, derived as 1+ID_W+UWIDTH; the adder `UWIDTH` must be set to this.

- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset. The adder `aresetn` is driven from `~rst` by the parent.
- `s_valid` / `s_ready` / `s_last`  in/out/in  NUM_REQ  per-requester handshake and packet end.
- `s_data_a`, `s_data_b`  in  NUM_REQ*DWIDTH  operands, requester i at slice [i*DWIDTH +: DWIDTH].
- `s_user`  in  NUM_REQ*UWIDTH  requester sideband.
- `add_s_valid`, `add_s_ready`, `add_s_data_a`, `add_s_data_b`, `add_s_user` (ADD_UWIDTH = {last, id, user}): out/in/out/out/out, connect to the adder input.
- `add_m_valid`, `add_m_ready`, `add_m_data_a`, `add_m_data_b`, `add_m_data_result`, `add_m_data_carry`, `add_m_user`: in/out/in/in/in/in/in, connect to the adder output.
- `r_valid` / `r_ready`  out/in  NUM_REQ  per-requester result handshake.
- `r_data_a`, `r_data_b`, `r_result`  out  DWIDTH  broadcast to all requesters.
- `r_carry`, `r_last`  out  1  broadcast.
- `r_user`  out  UWIDTH  broadcast.
- `id_err`  out  1  sticky; set on an out-of-range result tag.

## Operation
- FSM states: IDLE and LOCKED. The registered grant index is `gnt`, the registered last-served index is `last_gnt`.
- IDLE: scan `s_valid` from (last_gnt+1) mod NUM_REQ upward, wrapping. On the first set bit, register `gnt`, go to LOCKED. If no bit is set, stay in IDLE.
- LOCKED:
  - `add_s_valid = s_valid[gnt]` and `s_ready[gnt] = add_s_ready`. All other `s_ready` are 0.
  - Data and user pass combinationally from the granted requester.
  - `add_s_user = {s_last[gnt], gnt, s_user[gnt]}`.
- On a handshake with `s_last[gnt]=1`: set `last_gnt <= gnt` and return to IDLE.
- A granted requester that drops `s_valid` between beats keeps the lock. There is no timeout.
- Result path is purely combinational:
  - `id = add_m_user[UWIDTH +: ID_W]`.
  - `r_valid[i] = add_m_valid && id==i`.
  - `add_m_ready = r_ready[id]`.
  - `r_last` and `r_user` are sliced from `add_m_user`. Data and carry are broadcast.
- If `id >= NUM_REQ` (NUM_REQ not a power of two): force `add_m_ready=1`, drive all `r_valid` to 0, and set `id_err` when `add_m_valid` is 1. `id_err` is cleared only by `rst`.
- Responses are not reordered. The adder preserves order, so packets return in grant order.

## Timing
- Reset values:
  - state IDLE, `gnt=0`, `last_gnt=NUM_REQ-1` (requester 0 is first priority), `id_err=0`.
  - All `s_ready` = 0 and `add_s_valid=0` during reset and in IDLE.
- Grant latency: requester valid in cycle n is seen in IDLE, LOCKED in cycle n+1, first beat can handshake in n+1.
- There is exactly one bubble cycle (IDLE) between consecutive packets, including back-to-back packets from the same requester.
- Result latency equals the adder latency. The arbiter adds 0 cycles on the return path.
- When `rst` is asserted mid-packet, the FSM goes to IDLE on the next edge. The partial packet is abandoned, and the adder is flushed by the same reset.
- With simultaneous requests from all requesters, service order is 0,1,2,…,NUM_REQ-1,0 (one packet each).

## Structure
- Package `axi_add_arb_pkg`:
  - state enum `arb_state_t` {ARB_IDLE, ARB_LOCKED}.
  - function `arb_id_w(n)` returning max(1, clog2(n)).
- Sub-module `rr_pick`: combinational round-robin priority encoder. Inputs are a request vector and a start index; outputs are a found flag and an index. It is reusable elsewhere.
- The top holds the FSM, the grant registers, the input mux, and the result demux.

## Test plan
- Reset, then requester 2 alone sends 3 beats a=5,b=7 (last on beat 3) → grant in 1 cycle; results 12,12,12 appear only on `r_valid[2]` with `r_last` on the third.
- All 4 requesters send 2-beat packets simultaneously → adder input order is requesters 0,1,2,3, one idle cycle between packets, no interleaving within a packet.
- a=0xFFFFFFFF, b=1 from requester 1 → `r_result=0`, `r_carry=1` on `r_valid[1]`.
- Requester 3 holds `r_ready[3]=0` for 10 cycles → adder output stalls, no beat is lost, and other requesters' `r_valid` stay 0.
- Assert `rst` after beat 2 of a 5-beat packet from requester 1, then release → FSM in IDLE, `s_ready` all 0 during reset; next grant goes to requester 0 when both 0 and 1 request.
- NUM_REQ=3, inject an adder output with tag 3 → `add_m_ready=1`, no `r_valid`, `id_err` is 1 from the next cycle until `rst`.
